msi_snoop_bus: RTL and testbench

// Shared snooping-bus controller for the MSI caches: arbitrates bus requests from NUM_CACHES

---
 rtl/msi_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/msi_snoop_bus.sv | 236 +++++++++++++++++++++++
 tb/tb_msi_snoop_bus.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msi_pkg
// Purpose  : Shared definitions for the MSI snooping bus and the cache
//            controllers. Covers the bus message encodings and the bus
//            controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package msi_pkg;

  // Bus message encodings carried on bus_msg_o and req_msg_i
  localparam logic [1:0] BUS_RD    = 2'b00;
  localparam logic [1:0] BUS_RDX   = 2'b01;
  localparam logic [1:0] BUS_UPGR  = 2'b10;
  localparam logic [1:0] BUS_FLUSH = 2'b11;

  // Bus controller transaction sequencing
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BCAST = 3'd1,
    ST_SNOOP = 3'd2,
    ST_FLUSH = 3'd3,
    ST_MEM   = 3'd4,
    ST_DONE  = 3'd5
  } bus_state_e;

  // An upgrade needs no data, so a clean snoop completes it without memory.
  function automatic logic is_upgrade(input logic [1:0] msg);
    return msg == BUS_UPGR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. Searches the request vector
//            starting at the pointer position and wrapping around; the first
//            asserted request wins.
// Ports    : req_i   in  N        request vector
//            ptr_i   in  IDX_W    search start position (< N)
//            gnt_o   out N        one-hot grant (0 when no request)
//            idx_o   out IDX_W    index of the granted requester
//            vld_o   out 1        at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  int               w_pos;
  logic [IDX_W-1:0] w_sel;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    w_pos = 0;
    w_sel = '0;
    for (int i = 0; i < N; i++) begin
      // Wrap the search position without a modulo on a non-power-of-two N
      w_pos = int'(ptr_i) + i;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end
      w_sel = IDX_W'(w_pos);
      if (!vld_o && req_i[w_sel]) begin
        vld_o        = 1'b1;
        idx_o        = w_sel;
        gnt_o[w_sel] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/msi_snoop_bus.sv
`default_nettype none
// ============================================================================
// Module   : msi_snoop_bus
// Purpose  : Shared snooping-bus controller for MSI caches. Arbitrates bus
//            requests round-robin, broadcasts the granted message to all
//            snoopers, samples flush responses, sequences memory read or
//            write-back, and pulses completion back to the requester.
// Ports    : clk_i        in  1              clock (rising edge)
//            rst_i        in  1              async active-low reset
//            req_vld_i    in  NUM_CACHES     per-cache request, held to done
//            req_msg_i    in  2*NUM_CACHES   per-cache message
//            req_addr_i   in  ADDR_W*NUM     per-cache line address
//            grant_o      out NUM_CACHES     one-hot transaction owner
//            bus_vld_o    out 1              broadcast strobe
//            bus_msg_o    out 2              broadcast message
//            bus_addr_o   out ADDR_W         broadcast line address
//            snp_flush_i  in  NUM_CACHES     snooper flush responses
//            mem_rd_o     out 1              memory read in progress
//            mem_wr_o     out 1              memory write-back strobe
//            mem_addr_o   out ADDR_W         memory address
//            done_o       out NUM_CACHES     completion pulse
//            data_c2c_o   out 1              data came cache-to-cache
//            err_o        out 1              sticky protocol error
// Revision : 1.0 - initial release
// ============================================================================
module msi_snoop_bus #(
  parameter int NUM_CACHES = 2,
  parameter int ADDR_W     = 1,
  parameter int MEM_LAT    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CACHES-1:0]        req_vld_i,
  input  logic [2*NUM_CACHES-1:0]      req_msg_i,
  input  logic [ADDR_W*NUM_CACHES-1:0] req_addr_i,
  output logic [NUM_CACHES-1:0]        grant_o,
  output logic                         bus_vld_o,
  output logic [1:0]                   bus_msg_o,
  output logic [ADDR_W-1:0]            bus_addr_o,
  input  logic [NUM_CACHES-1:0]        snp_flush_i,
  output logic                         mem_rd_o,
  output logic                         mem_wr_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [NUM_CACHES-1:0]        done_o,
  output logic                         data_c2c_o,
  output logic                         err_o
);

  import msi_pkg::*;

  localparam int IDX_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  bus_state_e              r_state;
  bus_state_e              w_state_nxt;

  logic [IDX_W-1:0]        r_ptr;
  logic [NUM_CACHES-1:0]   r_grant;
  logic [1:0]              r_msg;
  logic [ADDR_W-1:0]       r_addr;
  logic                    r_c2c;
  logic                    r_err;
  logic [CNT_W-1:0]        r_cnt;

  logic [NUM_CACHES-1:0]   w_arb_gnt;
  logic [IDX_W-1:0]        w_arb_idx;
  logic                    w_arb_vld;
  logic [IDX_W-1:0]        w_ptr_nxt;

  logic [1:0]              w_req_msg  [NUM_CACHES];
  logic [ADDR_W-1:0]       w_req_addr [NUM_CACHES];

  logic [NUM_CACHES-1:0]   w_snp;
  logic                    w_snp_any;
  logic                    w_snp_multi;
  logic                    w_busy;

  // Split the flat per-cache request buses into indexable arrays
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CACHES; gi++) begin : g_unpack
      assign w_req_msg[gi]  = req_msg_i[2*gi +: 2];
      assign w_req_addr[gi] = req_addr_i[ADDR_W*gi +: ADDR_W];
    end
  endgenerate

  rr_arbiter #(
    .N     (NUM_CACHES),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i (req_vld_i),
    .ptr_i (r_ptr),
    .gnt_o (w_arb_gnt),
    .idx_o (w_arb_idx),
    .vld_o (w_arb_vld)
  );

  assign w_ptr_nxt = (w_arb_idx == IDX_W'(NUM_CACHES - 1)) ? '0
                                                            : w_arb_idx + IDX_W'(1);

  // The requester never responds to its own broadcast; mask it out.
  // A vector with more than one bit set survives clearing its lowest bit.
  assign w_snp       = snp_flush_i & ~r_grant;
  assign w_snp_any   = |w_snp;
  assign w_snp_multi = |(w_snp & (w_snp - NUM_CACHES'(1)));
  assign w_busy      = (r_state != ST_IDLE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_vld) begin
          w_state_nxt = ST_BCAST;
        end
      end
      ST_BCAST: begin
        // A voluntary write-back needs no snoop: the requester owns the data
        w_state_nxt = (r_msg == BUS_FLUSH) ? ST_FLUSH : ST_SNOOP;
      end
      ST_SNOOP: begin
        if (w_snp_any) begin
          w_state_nxt = ST_FLUSH;
        end else if (is_upgrade(r_msg)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_MEM;
        end
      end
      ST_FLUSH: w_state_nxt = ST_DONE;
      ST_MEM: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_msg   <= '0;
      r_addr  <= '0;
      r_c2c   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_vld) begin
            r_grant <= w_arb_gnt;
            r_msg   <= w_req_msg[w_arb_idx];
            r_addr  <= w_req_addr[w_arb_idx];
            r_c2c   <= 1'b0;
            r_ptr   <= w_ptr_nxt;
          end
        end
        ST_SNOOP: begin
          if (w_snp_any) begin
            r_c2c <= 1'b1;
          end
          // Two owners of an M line, or an owner seen by an upgrader whose
          // own copy must have been S, both mean the caches disagree.
          if (w_snp_multi || (w_snp_any && is_upgrade(r_msg))) begin
            r_err <= 1'b1;
          end
          r_cnt <= CNT_W'(MEM_LAT);
        end
        ST_MEM: begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from registered state so reset clears them at once
  // --------------------------------------------------------------------------
  always_comb begin
    grant_o    = '0;
    bus_vld_o  = 1'b0;
    bus_msg_o  = '0;
    bus_addr_o = '0;
    mem_rd_o   = 1'b0;
    mem_wr_o   = 1'b0;
    mem_addr_o = '0;
    done_o     = '0;
    data_c2c_o = 1'b0;
    err_o      = r_err;
    if (w_busy) begin
      grant_o    = r_grant;
      bus_msg_o  = r_msg;
      bus_addr_o = r_addr;
    end
    case (r_state)
      ST_BCAST: bus_vld_o = 1'b1;
      ST_FLUSH: begin
        mem_wr_o   = 1'b1;
        mem_addr_o = r_addr;
      end
      ST_MEM: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = r_addr;
      end
      ST_DONE: begin
        done_o     = r_grant;
        data_c2c_o = r_c2c;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_msi_snoop_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_msi_snoop_bus
// Purpose  : Self-checking bench for msi_snoop_bus (3 caches, 2-bit address,
//            memory latency 4). A latency-table model predicts every output
//            each cycle; directed transactions pin the model with literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msi_snoop_bus;

  import msi_pkg::*;

  localparam int N   = 3;
  localparam int AW  = 2;
  localparam int LAT = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic [N-1:0]    req_vld_i = '0;
  logic [2*N-1:0]  req_msg_i = '0;
  logic [AW*N-1:0] req_addr_i = '0;
  logic [N-1:0]    snp_flush_i = '0;
  logic [N-1:0]    grant_o;
  logic            bus_vld_o;
  logic [1:0]      bus_msg_o;
  logic [AW-1:0]   bus_addr_o;
  logic            mem_rd_o;
  logic            mem_wr_o;
  logic [AW-1:0]   mem_addr_o;
  logic [N-1:0]    done_o;
  logic            data_c2c_o;
  logic            err_o;

  msi_snoop_bus #(
    .NUM_CACHES (N),
    .ADDR_W     (AW),
    .MEM_LAT    (LAT)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_vld_i   (req_vld_i),
    .req_msg_i   (req_msg_i),
    .req_addr_i  (req_addr_i),
    .grant_o     (grant_o),
    .bus_vld_o   (bus_vld_o),
    .bus_msg_o   (bus_msg_o),
    .bus_addr_o  (bus_addr_o),
    .snp_flush_i (snp_flush_i),
    .mem_rd_o    (mem_rd_o),
    .mem_wr_o    (mem_wr_o),
    .mem_addr_o  (mem_addr_o),
    .done_o      (done_o),
    .data_c2c_o  (data_c2c_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: a transaction is described by its age (cycles since acceptance)
  // and the age at which done pulses; every output follows from that.
  // --------------------------------------------------------------------------
  int            m_busy, m_ptr, m_win, m_age, m_done_age, m_rd, m_wb, m_c2c, m_err;
  logic [1:0]    m_msg;
  logic [AW-1:0] m_addr;
  logic [N-1:0]  e_grant, e_done;
  logic          e_vld, e_rd, e_wr, e_c2c, e_err;
  logic [1:0]    e_msg;
  logic [AW-1:0] e_addr, e_maddr;

  initial begin
    m_busy = 0; m_ptr = 0; m_err = 0; m_age = 0; m_done_age = 0;
    m_win = 0; m_rd = 0; m_wb = 0; m_c2c = 0; m_msg = '0; m_addr = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        m_busy = 0; m_ptr = 0; m_err = 0; m_age = 0;
      end
      e_grant = (m_busy != 0) ? N'(1 << m_win) : '0;
      e_vld   = (m_busy != 0) && (m_age == 1);
      e_msg   = (m_busy != 0) ? m_msg : '0;
      e_addr  = (m_busy != 0) ? m_addr : '0;
      e_rd    = (m_busy != 0) && (m_rd != 0) && (m_age >= 3) && (m_age < m_done_age);
      e_wr    = (m_busy != 0) && (m_wb != 0) && (m_age == m_done_age - 1);
      e_maddr = (e_rd || e_wr) ? m_addr : '0;
      e_done  = ((m_busy != 0) && (m_age == m_done_age)) ? e_grant : '0;
      e_c2c   = (m_busy != 0) && (m_age == m_done_age) && (m_c2c != 0);
      e_err   = (m_err != 0);
      chk("grant_o",    grant_o,    e_grant);
      chk("bus_vld_o",  bus_vld_o,  e_vld);
      chk("bus_msg_o",  bus_msg_o,  e_msg);
      chk("bus_addr_o", bus_addr_o, e_addr);
      chk("mem_rd_o",   mem_rd_o,   e_rd);
      chk("mem_wr_o",   mem_wr_o,   e_wr);
      chk("mem_addr_o", mem_addr_o, e_maddr);
      chk("done_o",     done_o,     e_done);
      chk("data_c2c_o", data_c2c_o, e_c2c);
      chk("err_o",      err_o,      e_err);
      if (rst_i) begin
        if (m_busy == 0) begin
          if (req_vld_i != '0) begin
            int cand;
            bit found;
            found = 0;
            for (int i = 0; i < N; i++) begin
              cand = (m_ptr + i) % N;
              if (!found && req_vld_i[cand]) begin
                found = 1;
                m_win = cand;
              end
            end
            m_busy = 1; m_age = 1; m_ptr = (m_win + 1) % N;
            m_msg  = req_msg_i[2*m_win +: 2];
            m_addr = req_addr_i[AW*m_win +: AW];
            m_c2c = 0; m_rd = 0; m_wb = 0;
            if (m_msg == BUS_FLUSH) begin
              m_wb = 1; m_done_age = 3;
            end else begin
              m_done_age = 99;
            end
          end
        end else begin
          if (m_age == 2 && m_msg != BUS_FLUSH) begin
            int resp;
            resp = $countones(snp_flush_i & ~N'(1 << m_win));
            if (resp > 0) begin
              m_wb = 1; m_c2c = 1; m_done_age = 4;
              if (resp > 1 || m_msg == BUS_UPGR) m_err = 1;
            end else if (m_msg == BUS_UPGR) begin
              m_done_age = 3;
            end else begin
              m_rd = 1; m_done_age = 3 + LAT;
            end
          end
          if (m_age == m_done_age) begin
            m_busy = 0; m_age = 0;
          end else begin
            m_age++;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic do_reset();
    rst_i = 1'b0;
    req_vld_i = '0;
    snp_flush_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  task automatic run_txn(input string nm, input int id, input logic [1:0] msg,
                         input logic [AW-1:0] addr, input logic [N-1:0] flush,
                         input int drop_at, input int exp_lat, input logic [N-1:0] exp_done,
                         input logic exp_c2c, input int exp_rd, input int exp_wr_off);
    int t0, n_rd, wr_off, dcy;
    logic [N-1:0] dvec;
    logic dc2c;
    bit got;
    @(posedge clk_i); #1;
    req_vld_i[id] = 1'b1;
    req_msg_i[2*id +: 2] = msg;
    req_addr_i[AW*id +: AW] = addr;
    t0 = cyc;
    n_rd = 0; wr_off = -1; got = 0; dcy = 0; dvec = '0; dc2c = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk_i);
      if (mem_rd_o) n_rd++;
      if (mem_wr_o && wr_off < 0) wr_off = cyc - t0;
      if (done_o != '0) begin
        got = 1; dcy = cyc; dvec = done_o; dc2c = data_c2c_o;
      end
      @(posedge clk_i); #1;
      if (got || (drop_at > 0 && cyc == t0 + drop_at)) req_vld_i[id] = 1'b0;
      snp_flush_i = (cyc == t0 + 2) ? flush : '0;
    end
    chk({nm, " done seen"}, got, 1);
    chk({nm, " latency"}, dcy - t0, exp_lat);
    chk({nm, " done vector"}, dvec, exp_done);
    chk({nm, " c2c"}, dc2c, exp_c2c);
    chk({nm, " mem_rd cycles"}, n_rd, exp_rd);
    chk({nm, " mem_wr offset"}, wr_off, exp_wr_off);
  endtask

  // Caches 0 and 1 both request BusUpgr; report completion order and the
  // gap between the first done and the next broadcast.
  task automatic rr_round(output logic [N-1:0] d0, output logic [N-1:0] d1, output int gap);
    int nd, dcy;
    logic [N-1:0] pend;
    nd = 0; dcy = 0; gap = -1; pend = '0; d0 = '0; d1 = '0;
    @(posedge clk_i); #1;
    req_msg_i = {BUS_UPGR, BUS_UPGR, BUS_UPGR};
    req_addr_i = {2'd0, 2'd2, 2'd1};
    req_vld_i = 3'b011;
    for (int k = 0; k < 40 && nd < 2; k++) begin
      @(negedge clk_i);
      if (bus_vld_o && nd == 1 && gap < 0) gap = cyc - dcy;
      if (done_o != '0) begin
        if (nd == 0) begin
          d0 = done_o; dcy = cyc;
        end else begin
          d1 = done_o;
        end
        nd++;
        pend = done_o;
      end
      @(posedge clk_i); #1;
      req_vld_i = req_vld_i & ~pend;
      pend = '0;
    end
    chk("rr done count", nd, 2);
  endtask

  logic [N-1:0] d0, d1;
  int gap, t0, n_bad;

  initial begin
    do_reset();
    @(negedge clk_i);
    chk("reset grant_o", grant_o, 0);
    chk("reset bus_vld_o", bus_vld_o, 0);
    chk("reset done_o", done_o, 0);
    chk("reset err_o", err_o, 0);

    run_txn("rd_mem",     0, BUS_RD,    2'd1, 3'b000, 0, 7, 3'b001, 1'b0, 4, -1);
    run_txn("rdx_c2c",    1, BUS_RDX,   2'd2, 3'b001, 0, 4, 3'b010, 1'b1, 0,  3);
    run_txn("upgr_clean", 0, BUS_UPGR,  2'd3, 3'b000, 0, 3, 3'b001, 1'b0, 0, -1);
    run_txn("flush_msg",  2, BUS_FLUSH, 2'd1, 3'b011, 0, 3, 3'b100, 1'b0, 0,  2);
    run_txn("self_mask",  1, BUS_RDX,   2'd0, 3'b010, 0, 7, 3'b010, 1'b0, 4, -1);
    run_txn("drop_early", 2, BUS_RD,    2'd3, 3'b001, 2, 4, 3'b100, 1'b1, 0,  3);
    @(negedge clk_i);
    chk("no err after clean traffic", err_o, 0);

    do_reset();
    rr_round(d0, d1, gap);
    chk("rr first",  d0, 3'b001);
    chk("rr second", d1, 3'b010);
    chk("rr next grant gap", gap, 2);
    rr_round(d0, d1, gap);
    chk("rr repeat first",  d0, 3'b001);
    chk("rr repeat second", d1, 3'b010);

    run_txn("two_flush",  2, BUS_RD,   2'd2, 3'b011, 0, 4, 3'b100, 1'b1, 0,  3);
    @(negedge clk_i);
    chk("err set by two flushers", err_o, 1);
    run_txn("after_err",  0, BUS_UPGR, 2'd1, 3'b000, 0, 3, 3'b001, 1'b0, 0, -1);
    @(negedge clk_i);
    chk("err sticky", err_o, 1);
    do_reset();
    @(negedge clk_i);
    chk("err cleared by reset", err_o, 0);

    run_txn("upgr_resp",  0, BUS_UPGR, 2'd2, 3'b100, 0, 4, 3'b001, 1'b1, 0,  3);
    @(negedge clk_i);
    chk("err upgrade with responder", err_o, 1);
    do_reset();

    // Reset while memory read is in flight
    @(posedge clk_i); #1;
    req_msg_i[1:0] = BUS_RD;
    req_addr_i[AW-1:0] = 2'd2;
    req_vld_i[0] = 1'b1;
    t0 = cyc;
    repeat (4) @(posedge clk_i);
    #1;
    chk("pre-abort mem_rd_o", mem_rd_o, 1);
    rst_i = 1'b0;
    #1;
    chk("abort grant_o", grant_o, 0);
    chk("abort mem_rd_o", mem_rd_o, 0);
    chk("abort mem_addr_o", mem_addr_o, 0);
    chk("abort bus_msg_o", bus_msg_o, 0);
    req_vld_i = '0;
    n_bad = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (done_o != '0 || mem_wr_o) n_bad++;
    end
    chk("abort no done or write-back", n_bad, 0);
    @(posedge clk_i); #1 rst_i = 1'b1;
    rr_round(d0, d1, gap);
    chk("pointer reset first", d0, 3'b001);
    chk("pointer reset second", d1, 3'b010);

    repeat (3) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
